prbs31_word_generator: RTL and testbench



---
 rtl/prbs31_word_generator.sv | 150 +++++++++++++++
 tb/tb_prbs31_word_generator.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs31_word_generator.sv
// prbs31_word_generator
// Transmit-side PRBS31 (x^31 + x^28 + 1) word source, 32 bits per clock.
// Word bit 0 is the earliest bit in time, bit 31 the latest. Optional
// single-word or burst bit-flip injection is applied to the output word
// only; the LFSR itself is never corrupted, so the downstream checker
// sees each isolated flip as exactly three errors.

module prbs31_word_generator #(
  parameter logic [30:0] SEED = 31'h7FFF_FFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        seed_load,
  input  logic [30:0] seed_in,
  input  logic        inject_single,
  input  logic        inject_burst,
  input  logic [7:0]  inject_burst_len,
  input  logic [4:0]  err_bit_pos,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        inject_busy,
  output logic [31:0] inject_count
);

  localparam int DATA_W = 32;
  localparam int STATE_W = 31;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } inj_state_t;

  // Next 32 stream bits from the last 31 (state[30] most recent).
  // b[n] = b[n-31] ^ b[n-28]; bits 28..31 of the word depend on bits
  // produced earlier in the same word.
  function automatic logic [DATA_W-1:0] prbs_word(input logic [STATE_W-1:0] s);
    logic [DATA_W-1:0] w;
    w        = '0;
    w[27:0]  = s[27:0] ^ s[30:3];
    w[30:28] = s[30:28] ^ w[2:0];
    w[31]    = w[0] ^ w[3];
    return w;
  endfunction

  // A zero state would lock the LFSR, so an all-zero seed falls back to SEED.
  function automatic logic [STATE_W-1:0] seed_sel(input logic [STATE_W-1:0] s);
    return (s == '0) ? SEED : s;
  endfunction

  // One-hot flip mask for a word bit position.
  function automatic logic [DATA_W-1:0] onehot(input logic [4:0] p);
    logic [DATA_W-1:0] m;
    m    = '0;
    m[p] = 1'b1;
    return m;
  endfunction

  logic [STATE_W-1:0] lfsr_q;
  inj_state_t         fsm_q;
  inj_state_t         fsm_d;
  logic [7:0]         remain_q;
  logic [7:0]         remain_d;
  logic [4:0]         pos_q;
  logic [4:0]         pos_d;
  logic [DATA_W-1:0]  flip_mask;
  logic [DATA_W-1:0]  word_p0;
  logic               gen_p0;

  // Stage 0: clean word from the current state, and whether a word is emitted.
  assign word_p0     = prbs_word(lfsr_q);
  assign gen_p0      = enable && !seed_load;
  assign inject_busy = (fsm_q == BURST);

  // Injection FSM next state, burst bookkeeping and the flip mask for this word.
  always_comb begin
    fsm_d     = fsm_q;
    remain_d  = remain_q;
    pos_d     = pos_q;
    flip_mask = '0;
    if (seed_load) begin
      fsm_d = IDLE;
    end else if (enable) begin
      case (fsm_q)
        IDLE: begin
          if (inject_burst && (inject_burst_len != 8'd0)) begin
            pos_d     = err_bit_pos;
            flip_mask = onehot(err_bit_pos);
            // This word is the first of the burst; a length of one ends here.
            if (inject_burst_len != 8'd1) begin
              fsm_d    = BURST;
              remain_d = inject_burst_len - 8'd1;
            end
          end else if (inject_single) begin
            flip_mask = onehot(err_bit_pos);
          end
        end
        BURST: begin
          flip_mask = onehot(pos_q);
          if (remain_q == 8'd1) begin
            fsm_d = IDLE;
          end else begin
            remain_d = remain_q - 8'd1;
          end
        end
        default: begin
          fsm_d = IDLE;
        end
      endcase
    end
  end

  // Injection FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // Burst position and remaining count only matter while in BURST, so they carry no reset.
  always_ff @(posedge clock) begin
    remain_q <= remain_d;
    pos_q    <= pos_d;
  end

  // Stage 1: LFSR advance, registered output word and injection counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q       <= SEED;
      data_out     <= '0;
      data_valid   <= 1'b0;
      inject_count <= '0;
    end else if (seed_load) begin
      lfsr_q     <= seed_sel(seed_in);
      data_valid <= 1'b0;
    end else if (gen_p0) begin
      lfsr_q     <= word_p0[31:1];
      data_out   <= word_p0 ^ flip_mask;
      data_valid <= 1'b1;
      if (flip_mask != '0) begin
        inject_count <= inject_count + 32'd1;
      end
    end else begin
      data_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prbs31_word_generator.sv
// Testbench for prbs31_word_generator: directed vector table, hand-written
// multi-cycle corner cases and a randomized run, all against a bit-serial
// reference model of the PRBS31 stream and the injection rules.

module tb_prbs31_word_generator;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        seed_load;
  logic [30:0] seed_in;
  logic        inject_single;
  logic        inject_burst;
  logic [7:0]  inject_burst_len;
  logic [4:0]  err_bit_pos;
  logic [31:0] data_out;
  logic        data_valid;
  logic        inject_busy;
  logic [31:0] inject_count;

  localparam logic [30:0] TB_SEED = 31'h7FFF_FFFF;

  prbs31_word_generator #(.SEED(TB_SEED)) dut (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .seed_load        (seed_load),
    .seed_in          (seed_in),
    .inject_single    (inject_single),
    .inject_burst     (inject_burst),
    .inject_burst_len (inject_burst_len),
    .err_bit_pos      (err_bit_pos),
    .data_out         (data_out),
    .data_valid       (data_valid),
    .inject_busy      (inject_busy),
    .inject_count     (inject_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  bit          hist[$];   // last 31 stream bits, oldest first
  logic [31:0] m_data;
  logic [31:0] m_clean;
  logic        m_valid;
  logic        m_busy;
  logic [31:0] m_cnt;
  int          m_left;    // flips still owed by the running burst
  logic [4:0]  m_pos;

  function automatic void model_load(input logic [30:0] s);
    logic [30:0] v;
    v = (s == 31'd0) ? TB_SEED : s;
    hist.delete();
    for (int k = 0; k < 31; k++) hist.push_back(v[k]);
  endfunction

  function automatic logic [31:0] model_gen();
    logic [31:0] w;
    bit nb;
    for (int i = 0; i < 32; i++) begin
      nb = hist[0] ^ hist[3];   // b[n-31] ^ b[n-28]
      w[i] = nb;
      hist.push_back(nb);
      void'(hist.pop_front());
    end
    return w;
  endfunction

  function automatic void model_step(input logic rst, input logic en, input logic sl,
                                     input logic [30:0] seed, input logic single,
                                     input logic burst, input logic [7:0] len,
                                     input logic [4:0] pos);
    logic [31:0] mask;
    mask = '0;
    if (rst) begin
      model_load(TB_SEED);
      m_data = '0; m_valid = 1'b0; m_busy = 1'b0; m_cnt = '0; m_left = 0;
    end else if (sl) begin
      model_load(seed);
      m_valid = 1'b0; m_busy = 1'b0; m_left = 0;
    end else if (en) begin
      m_clean = model_gen();
      if (m_left > 0) begin
        mask = 32'd1 << m_pos;
        m_left = m_left - 1;
      end else if (burst && len != 8'd0) begin
        m_pos = pos;
        mask = 32'd1 << pos;
        m_left = int'(len) - 1;
      end else if (single) begin
        mask = 32'd1 << pos;
      end
      m_busy  = (m_left > 0);
      m_data  = m_clean ^ mask;
      m_valid = 1'b1;
      if (mask != 0) m_cnt = m_cnt + 32'd1;
    end else begin
      m_valid = 1'b0;
    end
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_cycle(input logic rst, input logic en, input logic sl,
                          input logic [30:0] seed, input logic single, input logic burst,
                          input logic [7:0] len, input logic [4:0] pos);
    reset = rst; enable = en; seed_load = sl; seed_in = seed;
    inject_single = single; inject_burst = burst; inject_burst_len = len; err_bit_pos = pos;
    model_step(rst, en, sl, seed, single, burst, len, pos);
    @(posedge clock);
    #1;
    check("model data_out", data_out, m_data);
    check("model data_valid", {31'd0, data_valid}, {31'd0, m_valid});
    check("model inject_busy", {31'd0, inject_busy}, {31'd0, m_busy});
    check("model inject_count", inject_count, m_cnt);
  endtask

  typedef struct {
    logic        en;
    logic        sl;
    logic [30:0] seed;
    logic        single;
    logic        burst;
    logic [7:0]  len;
    logic [4:0]  pos;
    logic        exp_valid;
    logic [31:0] exp_flip;
    logic        exp_busy;
    logic [31:0] exp_cnt;
    logic        chk_word;
    logic [31:0] exp_word;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic sl, input logic [30:0] seed,
                              input logic single, input logic burst, input logic [7:0] len,
                              input logic [4:0] pos, input logic ev, input logic [31:0] ef,
                              input logic eb, input logic [31:0] ec, input logic cw,
                              input logic [31:0] ew);
    vec_t v;
    v.en = en; v.sl = sl; v.seed = seed; v.single = single; v.burst = burst;
    v.len = len; v.pos = pos; v.exp_valid = ev; v.exp_flip = ef; v.exp_busy = eb;
    v.exp_cnt = ec; v.chk_word = cw; v.exp_word = ew;
    return v;
  endfunction

  vec_t vecs[23];

  initial begin
    //                en sl seed        sgl brs len  pos  val flip          busy cnt  chk word
    vecs[0]  = mk(1, 0, 31'd0,       0, 0, 8'd0, 5'd0,  1, 32'h0,        0, 32'd0, 1, 32'h7000_0000);
    vecs[1]  = mk(1, 0, 31'd0,       0, 0, 8'd0, 5'd0,  1, 32'h0,        0, 32'd0, 1, 32'h3F00_0000);
    vecs[2]  = mk(1, 0, 31'd0,       1, 0, 8'd0, 5'd5,  1, 32'h20,       0, 32'd1, 0, 32'h0);
    vecs[3]  = mk(1, 0, 31'd0,       0, 0, 8'd0, 5'd0,  1, 32'h0,        0, 32'd1, 0, 32'h0);
    vecs[4]  = mk(1, 0, 31'd0,       1, 1, 8'd4, 5'd31, 1, 32'h8000_0000, 1, 32'd2, 0, 32'h0);
    vecs[5]  = mk(1, 0, 31'd0,       0, 0, 8'd0, 5'd0,  1, 32'h8000_0000, 1, 32'd3, 0, 32'h0);
    vecs[6]  = mk(0, 0, 31'd0,       0, 0, 8'd0, 5'd0,  0, 32'h0,        1, 32'd3, 0, 32'h0);
    vecs[7]  = mk(0, 0, 31'd0,       1, 0, 8'd0, 5'd2,  0, 32'h0,        1, 32'd3, 0, 32'h0);
    vecs[8]  = mk(1, 0, 31'd0,       0, 1, 8'd5, 5'd1,  1, 32'h8000_0000, 1, 32'd4, 0, 32'h0);
    vecs[9]  = mk(1, 0, 31'd0,       0, 0, 8'd0, 5'd0,  1, 32'h8000_0000, 0, 32'd5, 0, 32'h0);
    vecs[10] = mk(1, 0, 31'd0,       0, 0, 8'd0, 5'd0,  1, 32'h0,        0, 32'd5, 0, 32'h0);
    vecs[11] = mk(1, 0, 31'd0,       0, 1, 8'd0, 5'd9,  1, 32'h0,        0, 32'd5, 0, 32'h0);
    vecs[12] = mk(0, 0, 31'd0,       0, 1, 8'd3, 5'd9,  0, 32'h0,        0, 32'd5, 0, 32'h0);
    vecs[13] = mk(0, 0, 31'd0,       1, 0, 8'd0, 5'd9,  0, 32'h0,        0, 32'd5, 0, 32'h0);
    vecs[14] = mk(1, 0, 31'd0,       0, 0, 8'd0, 5'd0,  1, 32'h0,        0, 32'd5, 0, 32'h0);
    vecs[15] = mk(1, 0, 31'd0,       0, 1, 8'd3, 5'd0,  1, 32'h1,        1, 32'd6, 0, 32'h0);
    vecs[16] = mk(1, 0, 31'd0,       0, 0, 8'd0, 5'd0,  1, 32'h1,        1, 32'd7, 0, 32'h0);
    vecs[17] = mk(1, 1, 31'd0,       0, 0, 8'd0, 5'd0,  0, 32'h0,        0, 32'd7, 0, 32'h0);
    vecs[18] = mk(1, 0, 31'd0,       0, 0, 8'd0, 5'd0,  1, 32'h0,        0, 32'd7, 1, 32'h7000_0000);
    vecs[19] = mk(1, 0, 31'd0,       0, 1, 8'd1, 5'd7,  1, 32'h80,       0, 32'd8, 0, 32'h0);
    vecs[20] = mk(1, 0, 31'd0,       0, 0, 8'd0, 5'd0,  1, 32'h0,        0, 32'd8, 0, 32'h0);
    vecs[21] = mk(1, 1, 31'h0123_4567, 0, 1, 8'd3, 5'd4, 0, 32'h0,       0, 32'd8, 0, 32'h0);
    vecs[22] = mk(1, 0, 31'd0,       0, 0, 8'd0, 5'd0,  1, 32'h0,        0, 32'd8, 0, 32'h0);
  end

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b1; enable = 1'b0; seed_load = 1'b0; seed_in = '0;
    inject_single = 1'b0; inject_burst = 1'b0; inject_burst_len = '0; err_bit_pos = '0;
    m_clean = '0; m_pos = '0;

    // Reset state.
    do_cycle(1, 0, 0, 31'd0, 0, 0, 8'd0, 5'd0);
    do_cycle(1, 0, 0, 31'd0, 0, 0, 8'd0, 5'd0);
    check("reset data_out", data_out, 32'h0);
    check("reset data_valid", {31'd0, data_valid}, 32'd0);
    check("reset inject_busy", {31'd0, inject_busy}, 32'd0);
    check("reset inject_count", inject_count, 32'd0);

    // Directed vector table.
    for (int i = 0; i < 23; i++) begin
      do_cycle(0, vecs[i].en, vecs[i].sl, vecs[i].seed, vecs[i].single, vecs[i].burst,
               vecs[i].len, vecs[i].pos);
      check($sformatf("vec%0d data_valid", i), {31'd0, data_valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d inject_busy", i), {31'd0, inject_busy}, {31'd0, vecs[i].exp_busy});
      check($sformatf("vec%0d inject_count", i), inject_count, vecs[i].exp_cnt);
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d flip", i), data_out ^ m_clean, vecs[i].exp_flip);
      if (vecs[i].chk_word)
        check($sformatf("vec%0d word", i), data_out, vecs[i].exp_word);
    end

    // Reset in the middle of a burst.
    do_cycle(0, 1, 0, 31'd0, 0, 1, 8'd10, 5'd3);
    check("midreset busy before", {31'd0, inject_busy}, 32'd1);
    do_cycle(0, 1, 0, 31'd0, 0, 0, 8'd0, 5'd0);
    do_cycle(1, 1, 0, 31'd0, 1, 0, 8'd0, 5'd0);
    check("midreset data_out", data_out, 32'h0);
    check("midreset busy", {31'd0, inject_busy}, 32'd0);
    check("midreset count", inject_count, 32'd0);
    do_cycle(0, 1, 0, 31'd0, 0, 0, 8'd0, 5'd0);
    check("midreset first word", data_out, 32'h7000_0000);
    check("midreset busy after", {31'd0, inject_busy}, 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic r_rst, r_en, r_sl, r_single, r_burst;
      logic [30:0] r_seed;
      r_rst    = ($urandom_range(0, 299) == 0);
      r_en     = ($urandom_range(0, 9) < 8);
      r_sl     = ($urandom_range(0, 49) == 0);
      r_single = ($urandom_range(0, 9) == 0);
      r_burst  = ($urandom_range(0, 19) == 0);
      r_seed   = ($urandom_range(0, 3) == 0) ? 31'd0 : 31'($urandom);
      do_cycle(r_rst, r_en, r_sl, r_seed, r_single, r_burst,
               8'($urandom_range(0, 6)), 5'($urandom_range(0, 31)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
